// File: rtl/axi4l_pkg.sv
// Shared definitions for the AXI4-Lite register bank: response codes,
// write/read channel state encodings and a constant-width helper.
package axi4l_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_COMMIT,
        W_RESP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rstate_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/axi4l_byte_reg.sv
// One DATA_W register with a per-register reset value, byte-strobed write
// enable, and a flop that pulses for one cycle after each committed write.
module axi4l_byte_reg
    import axi4l_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                aclk,
    input  logic                areset_n,
    input  logic                we,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   q,
    output logic                wr_pulse
);

    localparam int NB = DATA_W / 8;

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            q        <= RESET_VAL;
            wr_pulse <= 1'b0;
        end else begin
            // The pulse fires even when no strobe bit is set.
            wr_pulse <= we;
            for (int k = 0; k < NB; k++) begin
                if (we && wstrb[k]) begin
                    q[k*8 +: 8] <= wdata[k*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/axi4l_reg_bank.sv
// AXI4-Lite leaf slave exposing NREGS read/write registers to fabric, with
// byte strobes, SLVERR on unmapped indices and a per-register write pulse.
module axi4l_reg_bank
    import axi4l_pkg::*;
#(
    parameter int                      NREGS     = 4,
    parameter int                      DATA_W    = 32,
    parameter int                      ADDR_W    = 5,
    parameter logic [NREGS*DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                    aclk,
    input  logic                    areset_n,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ADDR_W-1:0]       awaddr,
    input  logic [2:0]              awprot,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [DATA_W-1:0]       wdata,
    input  logic [DATA_W/8-1:0]     wstrb,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [1:0]              bresp,
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [ADDR_W-1:0]       araddr,
    input  logic [2:0]              arprot,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [DATA_W-1:0]       rdata,
    output logic [1:0]              rresp,
    output logic [NREGS*DATA_W-1:0] regs_o,
    output logic [NREGS-1:0]        wr_pulse_o
);

    localparam int NB    = DATA_W / 8;
    localparam int LSB   = clog2(NB);
    localparam int IDX_W = ADDR_W - LSB;

    wstate_t w_state, w_next;
    rstate_t r_state, r_next;

    logic              aw_hs, w_hs, ar_hs;
    logic              aw_held, w_held;
    logic [IDX_W-1:0]  wr_idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic [NB-1:0]     wstrb_q;
    logic              wr_mapped;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_mapped;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] reg_q [NREGS];
    logic              unused_ok;

    assign unused_ok = ^{awprot, arprot, awaddr[LSB-1:0], araddr[LSB-1:0]};

    assign aw_hs     = awvalid && awready;
    assign w_hs      = wvalid && wready;
    assign ar_hs     = arvalid && arready;
    assign wr_mapped = int'(wr_idx_q) < NREGS;
    assign rd_idx    = araddr[ADDR_W-1:LSB];
    assign rd_mapped = int'(rd_idx) < NREGS;

    // Write channel: AW and W collect independently, then one commit cycle.
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:   if ((aw_held || aw_hs) && (w_held || w_hs)) w_next = W_COMMIT;
            W_COMMIT: w_next = W_RESP;
            W_RESP:   if (bready) w_next = W_IDLE;
            default:  w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            w_state <= W_IDLE;
            awready <= 1'b1;
            wready  <= 1'b1;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
        end else begin
            w_state <= w_next;
            if (aw_hs) begin
                awready <= 1'b0;
                aw_held <= 1'b1;
            end
            if (w_hs) begin
                wready <= 1'b0;
                w_held <= 1'b1;
            end
            if (w_state == W_COMMIT) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
            end
            if (w_state == W_RESP && bready) begin
                bvalid  <= 1'b0;
                awready <= 1'b1;
                wready  <= 1'b1;
            end
        end
    end

    // Payload latches need no reset: the held flags gate every use of them.
    always_ff @(posedge aclk) begin
        if (aw_hs) wr_idx_q <= awaddr[ADDR_W-1:LSB];
        if (w_hs) begin
            wdata_q <= wdata;
            wstrb_q <= wstrb;
        end
    end

    // Read channel: data is captured at the AR edge, so a same-edge commit is not visible.
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_RESP;
            R_RESP:  if (rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (int'(rd_idx) == i) rd_val = reg_q[i];
        end
    end

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            r_state <= R_IDLE;
            arready <= 1'b1;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
        end else begin
            r_state <= r_next;
            if (ar_hs) begin
                arready <= 1'b0;
                rvalid  <= 1'b1;
                rdata   <= rd_mapped ? rd_val : '0;
                rresp   <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
            end
            if (r_state == R_RESP && rready) begin
                rvalid  <= 1'b0;
                arready <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        axi4l_byte_reg #(
            .DATA_W    (DATA_W),
            .RESET_VAL (RESET_VAL[i*DATA_W +: DATA_W])
        ) u_reg (
            .aclk     (aclk),
            .areset_n (areset_n),
            .we       (w_state == W_COMMIT && wr_mapped && int'(wr_idx_q) == i),
            .wstrb    (wstrb_q),
            .wdata    (wdata_q),
            .q        (reg_q[i]),
            .wr_pulse (wr_pulse_o[i])
        );
        assign regs_o[i*DATA_W +: DATA_W] = reg_q[i];
    end

endmodule

// File: doc/axi4l_reg_bank.md
Name: axi4l_reg_bank

Overview:
Parametrised AXI4-Lite slave that exposes NREGS read/write registers of DATA_W bits, each driven out to fabric.
It is the next generation of the fixed two-register AXI4 byte-addressed slave, and adds:
- per-byte write strobes
- SLVERR on unmapped addresses
- a per-register write pulse
- per-register reset values
It sits between the interconnect and control logic as a leaf slave.

Parameters:
NREGS, 4, number of 32-bit-aligned registers (1..64).
DATA_W, 32, data width; 32 or 64 only; byte count NB = DATA_W/8.
ADDR_W, 5, AXI address width; must satisfy 2^ADDR_W >= NREGS*NB.
RESET_VAL, {NREGS*DATA_W}'0, flat per-register reset values; register i occupies bits [i*DATA_W +: DATA_W].

Ports:
aclk  in  1  clock; all logic on the rising edge.
areset_n  in  1  synchronous active-low reset.
awvalid/awready  in/out  1  write-address handshake.
awaddr  in  ADDR_W  byte address.
awprot  in  3  ignored.
wvalid/wready  in/out  1  write-data handshake.
wdata  in  DATA_W  write data.
wstrb  in  NB  byte enables.
bvalid/bready  out/in  1  write-response handshake.
bresp  out  2  00 OKAY, 10 SLVERR.
arvalid/arready  in/out  1  read-address handshake.
araddr  in  ADDR_W  byte address.
arprot  in  3  ignored.
rvalid/rready  out/in  1  read-data handshake.
rdata  out  DATA_W  read data.
rresp  out  2  00 OKAY, 10 SLVERR.
regs_o  out  NREGS*DATA_W  current register contents, flat.
wr_pulse_o  out  NREGS  one-cycle pulse in the cycle after register i commits a write.

Behaviour:
- Reset (areset_n low at a rising edge):
  - awready, wready, arready go to 1; bvalid, rvalid, wr_pulse_o go to 0.
  - bresp, rresp, rdata go to 0; registers load RESET_VAL.
  - Reset mid-transaction discards all latched AW/W/AR state; no commit occurs.
- Address decode:
  - idx = addr[ADDR_W-1 : log2(NB)]; low address bits are ignored.
  - idx >= NREGS is unmapped.
- Write channel (FSM W_IDLE -> W_COMMIT -> W_RESP -> W_IDLE):
  - In W_IDLE, AW and W are accepted independently, in either order or in the same cycle.
  - Each ready drops after its handshake and stays low until the response completes.
  - W_COMMIT is entered on the edge after both AW and W are held.
  - W_COMMIT lasts exactly one cycle. If mapped, each byte k of reg[idx] with wstrb[k]=1 takes wdata byte k; bytes with wstrb[k]=0 are unchanged.
  - wstrb=0 is a legal no-op write: OKAY, and the pulse is still asserted.
  - Unmapped: no register changes, no pulse, bresp=10.
  - The commit edge asserts bvalid and wr_pulse_o[idx] (one cycle).
  - W_RESP holds bvalid/bresp stable until bready. On the bready edge: bvalid=0, awready=wready=1.
  - Latency with AW+W together at edge T and bready held high: register updates at edge T+1, bvalid is high during cycle T+1, the channel is idle again after edge T+2.
- Read channel (FSM R_IDLE -> R_RESP):
  - On the AR handshake edge: rdata is latched (mapped: reg[idx]; unmapped: 0 with rresp=10), rvalid=1, arready=0.
  - rdata/rresp are held until rready. The rready edge sets rvalid=0, arready=1.
  - One outstanding read, one outstanding write.
- Simultaneous read and write:
  - Channels are fully independent.
  - An AR handshake on the same edge as a W_COMMIT to the same register returns the pre-write value.
  - A later read returns the new value.
- regs_o is driven directly from the registers; it changes on the commit edge.

Decomposition:
- Shared package axi4l_pkg:
  - response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - write FSM state enum (W_IDLE, W_COMMIT, W_RESP)
  - read FSM state enum (R_IDLE, R_RESP)
  - function clog2
- One sub-module axi4l_byte_reg: a single DATA_W register with RESET_VAL, byte-strobe write enable and the wr_pulse flop. It is instantiated NREGS times via generate.

Test Plan:
- Reset, then read every index -> rdata equals RESET_VAL slice, rresp=00; regs_o equals RESET_VAL.
- Write addr 0x4, wdata 0xAABBCCDD, wstrb 0xF over prior value 0x11223344 -> reg1=0xAABBCCDD; wr_pulse_o=0010 for exactly one cycle; bresp=00.
- Partial strobe: reg2=0x11223344, write 0xAABBCCDD with wstrb 0x5 -> reg2=0x11BB33DD.
- W presented 3 cycles before AW, and bready held low 4 cycles after bvalid -> single commit; bvalid stays high with bresp stable; awready/wready stay 0 until the bready edge.
- Unmapped write to 0x10 (NREGS=4, DATA_W=32) -> bresp=10, no register change, wr_pulse_o=0. Unmapped read -> rdata=0, rresp=10.
- AR to reg0 on the same edge as a commit of 0x5 to reg0 (old value 0x9) -> rdata=0x9. A second read -> 0x5. Assert areset_n low mid-W_RESP -> bvalid=0, all regs return to RESET_VAL next cycle.
